// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a four-state drain FSM.
// Latency: push at edge N -> pop at edge N+1 -> tx_dv_o high in the cycle after N+1 (ends at N+2).
// Backpressure: drain waits on tx_active_i/tx_done_i; pushes while full are dropped and flagged.
//
// Optional feature macro: UART_TX_FIFO_IRQ_EN (drain-complete interrupt).
//
// Ports:
//   clk_i          single clock, rising edge
//   reset_i        asynchronous, active-low reset
//   csb_i, wen_i   bus chip select / write enable (active-low)
//   wmask_i        bit0 = push data_i, bit1 = clear overflow flag
//   data_i         byte to enqueue
//   tx_active_i    transmitter busy
//   tx_done_i      transmitter one-cycle completion pulse
//   tx_dv_o        one-cycle start strobe to the transmitter
//   tx_byte_o      byte for the transmitter, held from LAUNCH until the next pop
//   count_o        occupancy, empty_o / full_o derived from it
//   overflow_o     sticky flag for a dropped push
//   tx_empty_irq_o drain-complete pulse (tied low without the macro)
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     csb_i,
  input  logic                     wen_i,
  input  logic [3:0]               wmask_i,
  input  logic [7:0]               data_i,
  input  logic                     tx_active_i,
  input  logic                     tx_done_i,
  output logic                     tx_dv_o,
  output logic [7:0]               tx_byte_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic                     tx_empty_irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Only powers of two from 2 to 256 are supported; stop elaboration otherwise.
  generate
    if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two in 2..256");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      tx_byte_q;
  logic            overflow_q;

  logic            bus_wr;
  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic            ovf_set;
  logic            ovf_clr;
  logic            unused_wmask;

  assign unused_wmask = ^wmask_i[3:2];

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign tx_byte_o  = tx_byte_q;
  assign tx_dv_o    = (state_q == LAUNCH);

  assign bus_wr   = !csb_i && !wen_i;
  assign push_req = bus_wr && wmask_i[0];
  // A pop in the same cycle frees the slot being written, so a full FIFO
  // still accepts the push.
  assign push_ok  = push_req && (!full_o || pop);
  assign ovf_set  = push_req && full_o && !pop;
  assign ovf_clr  = bus_wr && wmask_i[1];

  // Storage: contents need no reset, only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      overflow_q <= 1'b0;
    end else if (ovf_set) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  // Drain FSM state register and output byte register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      tx_byte_q <= 8'h00;
    end else begin
      state_q <= state_d;
      if (pop) begin
        tx_byte_q <= mem[rd_ptr_q];
      end
    end
  end

  // GAP covers the transmitter's cleanup cycle; tx_done_i only matters in BUSY.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_o && !tx_active_i) begin
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = BUSY;
      BUSY: begin
        if (tx_done_i) begin
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_TX_FIFO_IRQ_EN
  // Pulses in the first IDLE cycle after a GAP that found the FIFO empty.
  logic irq_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (state_q == GAP) && empty_o;
    end
  end

  assign tx_empty_irq_o = irq_q;
`else
  assign tx_empty_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo (DEPTH=16): vector table plus multi-cycle sequences.
// Latency: n/a.
// Backpressure: a small transmitter model drives tx_active_i/tx_done_i when enabled.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       csb_i = 1'b1;
  logic       wen_i = 1'b1;
  logic [3:0] wmask_i = 4'h0;
  logic [7:0] data_i = 8'h00;
  logic       tx_active_i;
  logic       tx_done_i;
  logic       tx_dv_o;
  logic [7:0] tx_byte_o;
  logic [4:0] count_o;
  logic       empty_o;
  logic       full_o;
  logic       overflow_o;
  logic       tx_empty_irq_o;

  // Transmitter input source: manual values or the model.
  logic model_en = 1'b0;
  logic man_active = 1'b0;
  logic man_done = 1'b0;
  logic model_active = 1'b0;
  logic model_done = 1'b0;
  int   model_left = 0;
  logic dv_seen;

  assign tx_active_i = model_en ? model_active : man_active;
  assign tx_done_i   = model_en ? model_done   : man_done;

  int total = 0;
  int bad = 0;

  int         cyc = 0;
  int         dv_q[$];
  logic [7:0] byte_q[$];
  int         done_q[$];
  int         irq_q[$];
  int         irq_total = 0;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .csb_i          (csb_i),
    .wen_i          (wen_i),
    .wmask_i        (wmask_i),
    .data_i         (data_i),
    .tx_active_i    (tx_active_i),
    .tx_done_i      (tx_done_i),
    .tx_dv_o        (tx_dv_o),
    .tx_byte_o      (tx_byte_o),
    .count_o        (count_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .overflow_o     (overflow_o),
    .tx_empty_irq_o (tx_empty_irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Transmitter model: busy for 4 cycles after a start strobe, then a done pulse.
  always @(posedge clk_i) begin
    dv_seen = tx_dv_o;
    #1;
    model_done = 1'b0;
    if (dv_seen) begin
      model_active = 1'b1;
      model_left   = 4;
    end else if (model_left > 0) begin
      model_left = model_left - 1;
      if (model_left == 0) begin
        model_done   = 1'b1;
        model_active = 1'b0;
      end
    end
  end

  // Monitor: values seen at each rising edge belong to the cycle that just ended.
  always @(posedge clk_i) begin
    if (tx_done_i) done_q.push_back(cyc);
    if (tx_dv_o) begin
      dv_q.push_back(cyc);
      byte_q.push_back(tx_byte_o);
    end
    if (tx_empty_irq_o) begin
      irq_q.push_back(cyc);
      irq_total = irq_total + 1;
    end
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    dv_q.delete();
    byte_q.delete();
    done_q.delete();
    irq_q.delete();
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_idle();
    csb_i = 1'b1;
    wen_i = 1'b1;
    wmask_i = 4'h0;
  endtask

  task automatic bus_write(input logic [3:0] m, input logic [7:0] d);
    csb_i = 1'b0;
    wen_i = 1'b0;
    wmask_i = m;
    data_i = d;
    tick();
    bus_idle();
  endtask

  task automatic push(input logic [7:0] d);
    bus_write(4'b0001, d);
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b1;
    repeat (8) tick();
  endtask

  task automatic wait_dv(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (dv_q.size() >= n) break;
      tick();
    end
  endtask

  typedef struct {
    logic       csb;
    logic       wen;
    logic [3:0] wmask;
    logic [7:0] data;
    logic       act;
    logic       done;
    logic [4:0] cnt;
    logic       emp;
    logic       full;
    logic       ovf;
    logic       dv;
    logic [7:0] tx_byte;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 400us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] got;
    logic [16:0] want;
    int errs;
    logic [7:0] exp_b;

    //            csb  wen  mask   data   act  done cnt emp full ovf dv  byte
    vecs[0]  = '{1'b0,1'b0,4'h1,8'h11,1'b1,1'b0,5'd1,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[1]  = '{1'b0,1'b0,4'h1,8'h22,1'b1,1'b0,5'd2,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[2]  = '{1'b1,1'b0,4'h1,8'h33,1'b1,1'b0,5'd2,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[3]  = '{1'b0,1'b1,4'h1,8'h33,1'b1,1'b0,5'd2,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[4]  = '{1'b0,1'b0,4'h0,8'h33,1'b1,1'b0,5'd2,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[5]  = '{1'b1,1'b1,4'h0,8'h00,1'b1,1'b1,5'd2,1'b0,1'b0,1'b0,1'b0,8'h00};
    vecs[6]  = '{1'b1,1'b1,4'h0,8'h00,1'b0,1'b0,5'd1,1'b0,1'b0,1'b0,1'b1,8'h11};
    vecs[7]  = '{1'b0,1'b0,4'h1,8'h33,1'b1,1'b0,5'd2,1'b0,1'b0,1'b0,1'b0,8'h11};
    vecs[8]  = '{1'b1,1'b1,4'h0,8'h00,1'b1,1'b1,5'd2,1'b0,1'b0,1'b0,1'b0,8'h11};
    vecs[9]  = '{1'b1,1'b1,4'h0,8'h00,1'b0,1'b0,5'd2,1'b0,1'b0,1'b0,1'b0,8'h11};
    vecs[10] = '{1'b1,1'b1,4'h0,8'h00,1'b0,1'b0,5'd1,1'b0,1'b0,1'b0,1'b1,8'h22};
    vecs[11] = '{1'b1,1'b1,4'h0,8'h00,1'b0,1'b0,5'd1,1'b0,1'b0,1'b0,1'b0,8'h22};
    vecs[12] = '{1'b0,1'b0,4'h1,8'h44,1'b0,1'b1,5'd2,1'b0,1'b0,1'b0,1'b0,8'h22};
    vecs[13] = '{1'b1,1'b1,4'h0,8'h00,1'b1,1'b0,5'd2,1'b0,1'b0,1'b0,1'b0,8'h22};
    vecs[14] = '{1'b1,1'b1,4'h0,8'h00,1'b1,1'b0,5'd2,1'b0,1'b0,1'b0,1'b0,8'h22};

    // Reset values while reset is held.
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_count", 32'(count_o), 32'd0);
    check("reset_flags", 32'({empty_o, full_o, overflow_o, tx_dv_o, tx_empty_irq_o}), 32'b10000);
    check("reset_byte", 32'(tx_byte_o), 32'h00);
    reset_i = 1'b1;
    repeat (4) tick();

    // Vector table, manual transmitter inputs.
    for (int i = 0; i < NV; i++) begin
      csb_i = vecs[i].csb;
      wen_i = vecs[i].wen;
      wmask_i = vecs[i].wmask;
      data_i = vecs[i].data;
      man_active = vecs[i].act;
      man_done = vecs[i].done;
      tick();
      got  = {count_o, empty_o, full_o, overflow_o, tx_dv_o, tx_byte_o};
      want = {vecs[i].cnt, vecs[i].emp, vecs[i].full, vecs[i].ovf, vecs[i].dv, vecs[i].tx_byte};
      check($sformatf("vec%0d", i), 32'(got), 32'(want));
    end
    bus_idle();
    man_done = 1'b0;
    man_active = 1'b0;
    do_reset();

    // Single byte latency with the transmitter model.
    model_en = 1'b1;
    clear_logs();
    push(8'hA5);
    check("single_cnt_after_push", 32'({count_o, tx_dv_o}), 32'({5'd1, 1'b0}));
    tick();
    check("single_launch", 32'({tx_dv_o, tx_byte_o, count_o}), 32'({1'b1, 8'hA5, 5'd0}));
    tick();
    check("single_busy_hold", 32'({tx_dv_o, tx_byte_o}), 32'({1'b0, 8'hA5}));
    repeat (15) tick();
    check("single_pulses", 32'(dv_q.size()), 32'd1);

    // Burst of three bytes: each start strobe 3 cycles after the prior done.
    clear_logs();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_dv(3, 200);
    repeat (10) tick();
    check("burst_pulses", 32'(dv_q.size()), 32'd3);
    if (dv_q.size() == 3 && done_q.size() >= 2) begin
      check("burst_order", 32'({byte_q[0], byte_q[1], byte_q[2]}), 32'h010203);
      check("burst_gap1", 32'(dv_q[1] - done_q[0]), 32'd3);
      check("burst_gap2", 32'(dv_q[2] - done_q[1]), 32'd3);
    end
    check("burst_empty", 32'({empty_o, count_o}), 32'({1'b1, 5'd0}));

    // Overflow, sticky flag, clear, set-wins and push+pop while full.
    model_en = 1'b0;
    man_active = 1'b1;
    clear_logs();
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    check("fill_16", 32'({full_o, count_o, overflow_o}), 32'({1'b1, 5'd16, 1'b0}));
    push(8'hEE);
    check("overflow_set", 32'({full_o, count_o, overflow_o}), 32'({1'b1, 5'd16, 1'b1}));
    bus_write(4'b0010, 8'h00);
    check("overflow_clear", 32'({count_o, overflow_o}), 32'({5'd16, 1'b0}));
    bus_write(4'b0011, 8'hEF);
    check("overflow_set_wins", 32'({count_o, overflow_o}), 32'({5'd16, 1'b1}));
    bus_write(4'b0010, 8'h00);
    man_active = 1'b0;
    push(8'h80);
    check("full_push_pop", 32'({full_o, count_o, overflow_o, tx_dv_o, tx_byte_o}),
          32'({1'b1, 5'd16, 1'b0, 1'b1, 8'h00}));
    model_en = 1'b1;
    wait_dv(17, 400);
    repeat (10) tick();
    check("full_drain_pulses", 32'(dv_q.size()), 32'd17);
    errs = 0;
    for (int i = 0; i < 17; i++) begin
      exp_b = (i == 16) ? 8'h80 : 8'(i);
      if (i >= byte_q.size() || byte_q[i] !== exp_b) errs++;
    end
    check("full_drain_order", 32'(errs), 32'd0);

    // Wrap: 40 bytes through a 16-entry buffer.
    clear_logs();
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 50 && full_o; k++) tick();
      push(8'(i * 5 + 7));
    end
    wait_dv(40, 600);
    repeat (10) tick();
    check("wrap_pulses", 32'(dv_q.size()), 32'd40);
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      if (i >= byte_q.size() || byte_q[i] !== 8'(i * 5 + 7)) errs++;
    end
    check("wrap_order", 32'(errs), 32'd0);
    check("wrap_empty", 32'({empty_o, count_o, overflow_o}), 32'({1'b1, 5'd0, 1'b0}));

    // Reset mid-stream while BUSY with five bytes queued.
    clear_logs();
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
    check("mid_count5", 32'({count_o, tx_dv_o}), 32'({5'd5, 1'b0}));
    reset_i = 1'b0;
    #1;
    check("mid_reset_vals", 32'({count_o, empty_o, full_o, overflow_o, tx_dv_o, tx_byte_o, tx_empty_irq_o}),
          32'({5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}));
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b1;
    clear_logs();
    repeat (30) tick();
    check("mid_no_dv", 32'({dv_q.size(), 32'(count_o)} != 0), 32'd0);
    push(8'h5A);
    repeat (3) tick();
    check("mid_new_push", 32'(dv_q.size()), 32'd1);
    if (byte_q.size() >= 1) check("mid_new_byte", 32'(byte_q[0]), 32'h5A);
    repeat (15) tick();

`ifdef UART_TX_FIFO_IRQ_EN
    clear_logs();
    push(8'hC1);
    push(8'hC2);
    wait_dv(2, 100);
    repeat (20) tick();
    check("irq_pulses", 32'(irq_q.size()), 32'd1);
    if (irq_q.size() == 1 && done_q.size() == 2) begin
      check("irq_timing", 32'(irq_q[0] - done_q[1]), 32'd2);
    end
`else
    check("irq_tied_low", 32'(irq_total), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
